// File: rtl/reg_write_dispatcher_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// reg_dispatch_pkg: shared types and helpers for the register-write dispatcher
// Rev 1.0
//------------------------------------------------------------------------------
package reg_dispatch_pkg;

  localparam int WIN_ADDR_W = 32;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [WIN_ADDR_W-1:0] start_a;
    logic [WIN_ADDR_W-1:0] end_a;
  } window_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_dispatcher_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// reg_write_dispatcher_if: config, requester and target buses of the dispatcher
// Rev 1.0
//------------------------------------------------------------------------------
interface reg_write_dispatcher_if
  import reg_dispatch_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_TGT = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic                        cfg_valid;
  logic [idx_w(NUM_TGT)-1:0]   cfg_tgt;
  logic [ADDR_W-1:0]           cfg_start;
  logic [ADDR_W-1:0]           cfg_end;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic                        rsp_err;

  logic [NUM_TGT-1:0]          tgt_wr;
  logic [ADDR_W-1:0]           tgt_addr;
  logic [DATA_W-1:0]           tgt_data;
  logic [NUM_TGT-1:0]          tgt_ack;

  modport slave (
    input  cfg_valid, cfg_tgt, cfg_start, cfg_end,
    input  req_valid, req_addr, req_data, tgt_ack,
    output req_ready, rsp_valid, rsp_err, tgt_wr, tgt_addr, tgt_data
  );

  modport master (
    output cfg_valid, cfg_tgt, cfg_start, cfg_end,
    output req_valid, req_addr, req_data, tgt_ack,
    input  req_ready, rsp_valid, rsp_err, tgt_wr, tgt_addr, tgt_data
  );

endinterface
`default_nettype wire

// File: rtl/reg_write_dispatcher_rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
// Rev 1.0
//------------------------------------------------------------------------------
module rr_arbiter
  import reg_dispatch_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_write_dispatcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// reg_write_dispatcher: arbitrates single register writes and routes them to
// the target owning the address window. Rev 1.0
//------------------------------------------------------------------------------
module reg_write_dispatcher
  import reg_dispatch_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_TGT = 3,
  parameter int ADDR_W  = WIN_ADDR_W,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_dispatcher_if.slave bus
);

  localparam int RW = idx_w(NUM_REQ);
  localparam int TW = idx_w(NUM_TGT);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT);

  state_e             state, state_nx;
  window_t            win [NUM_TGT];
  logic [NUM_REQ-1:0] gnt;
  logic [RW-1:0]      gnt_idx, gidx_q, rr_ptr;
  logic [ADDR_W-1:0]  addr_mux, addr_q;
  logic [DATA_W-1:0]  data_mux, data_q;
  logic [NUM_TGT-1:0] hit, sel_oh, sel_q;
  logic               sel_found, err_q, ack_sel;
  logic [CNT_W-1:0]   cnt_q;

  rr_arbiter #(.N(NUM_REQ), .PW(RW)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // An inverted window clears only the valid bit; the stale bounds are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TGT; t++) win[t] <= '0;
    end else if (bus.cfg_valid) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (bus.cfg_tgt == TW'(t)) begin
          if (bus.cfg_start > bus.cfg_end) win[t].valid <= 1'b0;
          else win[t] <= {1'b1, bus.cfg_start, bus.cfg_end};
        end
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        addr_mux = bus.req_addr[i*ADDR_W +: ADDR_W];
        data_mux = bus.req_data[i*DATA_W +: DATA_W];
        gnt_idx  = RW'(i);
      end
    end
  end

  // Lowest-indexed hit wins when windows overlap.
  always_comb begin
    hit       = '0;
    sel_oh    = '0;
    sel_found = 1'b0;
    for (int t = 0; t < NUM_TGT; t++) begin
      hit[t] = win[t].valid && (win[t].start_a <= addr_q) && (addr_q <= win[t].end_a);
      if (hit[t] && !sel_found) begin
        sel_oh[t] = 1'b1;
        sel_found = 1'b1;
      end
    end
  end

  assign ack_sel = |(bus.tgt_ack & sel_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|bus.req_valid) state_nx = DECODE;
      DECODE:  state_nx = (|hit) ? ISSUE : RESP;
      ISSUE:   if (ack_sel || cnt_q <= CNT_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      gidx_q <= '0;
      rr_ptr <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            addr_q <= addr_mux;
            data_q <= data_mux;
            gidx_q <= gnt_idx;
            rr_ptr <= (gnt_idx == RW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        DECODE: begin
          sel_q <= sel_oh;
          err_q <= ~|hit;
          cnt_q <= TIMEOUT_LD;
        end
        ISSUE: begin
          // An ack landing on the last counted cycle still wins over the timeout.
          cnt_q <= cnt_q - 1'b1;
          if (ack_sel)                    err_q <= 1'b0;
          else if (cnt_q <= CNT_W'(1))    err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_err   = 1'b0;
    bus.tgt_wr    = '0;
    bus.tgt_addr  = '0;
    bus.tgt_data  = '0;
    case (state)
      IDLE:  bus.req_ready = rst ? '0 : gnt;
      ISSUE: begin
        bus.tgt_wr   = sel_q;
        bus.tgt_addr = addr_q;
        bus.tgt_data = data_q;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gidx_q == RW'(i)) bus.rsp_valid[i] = 1'b1;
        end
        bus.rsp_err = err_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
